// File: rtl/shift_reg_pkg.sv
// Shared mode encodings and default width for the universal shift register.
// Imported by shift_reg and shift_reg_next.
package shift_reg_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_ROR  = 2'b11
    } mode_e;

    localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/shift_reg_next.sv
// Purpose: combinational next-state for the shift register (load / hold / shr / shl / ror).
// Latency: none, purely combinational. Backpressure: none, evaluated every cycle.
// SHIFT_REG_ARITH_EN turns MODE_SHR into an arithmetic (sign-replicating) shift.
module shift_reg_next
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] cur,
    input  logic [WIDTH-1:0] ip,
    input  logic             load,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] nxt
);

    logic shr_fill;

`ifdef SHIFT_REG_ARITH_EN
    assign shr_fill = cur[WIDTH-1];
`else
    assign shr_fill = 1'b0;
`endif

    always_comb begin
        nxt = cur;
        if (load) begin
            nxt = ip;
        end else begin
            // Unknown sel codes fall to default and keep the register unchanged.
            case (sel)
                MODE_HOLD: nxt = cur;
                MODE_SHR:  nxt = {shr_fill, cur[WIDTH-1:1]};
                MODE_SHL:  nxt = {cur[WIDTH-2:0], 1'b0};
                MODE_ROR:  nxt = {cur[0], cur[WIDTH-1:1]};
                default:   nxt = cur;
            endcase
        end
    end

endmodule

// File: rtl/shift_reg.sv
// Purpose: universal shift register with parallel load; contents drive op directly.
// Latency: 1 cycle from sampled inputs to op. Backpressure: none, updates every edge.
// SHIFT_REG_ARITH_EN (see shift_reg_next) selects arithmetic shift right.
module shift_reg
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] ip,
    input  logic             load,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] op
);

    logic [WIDTH-1:0] nxt;

    shift_reg_next #(
        .WIDTH (WIDTH)
    ) u_next (
        .cur  (op),
        .ip   (ip),
        .load (load),
        .sel  (sel),
        .nxt  (nxt)
    );

    // rst is active-low despite its name.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op <= '0;
        end else begin
            op <= nxt;
        end
    end

endmodule

// File: tb/tb_shift_reg.sv
// Directed plan plus randomized traffic against an arithmetic reference model.
module tb_shift_reg;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic [W-1:0] ip;
    logic         load;
    logic [1:0]   sel;
    logic [W-1:0] op;

    int checks;
    int errors;

    shift_reg #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .ip   (ip),
        .load (load),
        .sel  (sel),
        .op   (op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] model(input logic [W-1:0] cur, input logic ld,
                                           input logic [1:0] s, input logic [W-1:0] d);
        int v;
        int top;
        v   = int'(cur);
        top = 1 << (W - 1);
        if (ld) return d;
        case (s)
            2'd0: return cur;
`ifdef SHIFT_REG_ARITH_EN
            2'd1: return W'((v / 2) + (v & top));
`else
            2'd1: return W'(v / 2);
`endif
            2'd2: return W'((v * 2) % (1 << W));
            default: return W'((v / 2) + (v % 2) * top);
        endcase
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] mdl;
        logic [W-1:0] exp_shr [5];
        logic [W-1:0] exp_shl [3];
        logic [W-1:0] exp_ror [4];
        checks = 0;
        errors = 0;
`ifdef SHIFT_REG_ARITH_EN
        exp_shr = '{4'b1100, 4'b1110, 4'b1111, 4'b1111, 4'b1111};
`else
        exp_shr = '{4'b0100, 4'b0010, 4'b0001, 4'b0000, 4'b0000};
`endif
        exp_shl = '{4'b0100, 4'b1000, 4'b0000};
        exp_ror = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

        // Reset dominates a pending load, with and without clock edges.
        rst = 1'b0; load = 1'b1; ip = 4'b1100; sel = 2'b00;
        #2;
        chk("reset_immediate", op, 4'b0000);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("reset_held", op, 4'b0000);
        end
        rst = 1'b1;
        step();
        chk("reset_release_load", op, 4'b1100);

        load = 1'b0; sel = 2'b00; ip = 4'b0101;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold", op, 4'b1100);
        end

        load = 1'b1; ip = 4'b1000;
        step();
        chk("load_shr", op, 4'b1000);
        load = 1'b0; sel = 2'b01;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("shr", op, exp_shr[i]);
        end

        load = 1'b1; ip = 4'b1010;
        step();
        chk("load_shl", op, 4'b1010);
        load = 1'b0; sel = 2'b10;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("shl", op, exp_shl[i]);
        end

        load = 1'b1; ip = 4'b1110;
        step();
        chk("load_ror", op, 4'b1110);
        load = 1'b0; sel = 2'b11;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("ror", op, exp_ror[i]);
        end

        load = 1'b1; sel = 2'b11; ip = 4'b1111;
        step();
        chk("load_priority", op, 4'b1111);

        // Async reset pulse between edges.
        load = 1'b0; sel = 2'b00;
        #1 rst = 1'b0;
        #1 chk("async_pulse", op, 4'b0000);
        rst = 1'b1;
        step();
        chk("after_pulse_hold", op, 4'b0000);

        // Randomized traffic with occasional mid-operation resets.
        mdl = '0;
        for (int i = 0; i < 300; i++) begin
            load = ($urandom_range(0, 3) == 0);
            sel  = 2'($urandom_range(0, 3));
            ip   = W'($urandom);
            if ($urandom_range(0, 39) == 0) begin
                #1 rst = 1'b0;
                #1 chk("rand_reset", op, 4'b0000);
                rst = 1'b1;
                mdl = '0;
            end
            mdl = model(mdl, load, sel, ip);
            step();
            chk("random", op, mdl);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_reg.md
Name: shift_reg

Overview:
- Parameterised universal shift register with synchronous parallel load and mode-selected hold, shift-right, shift-left and rotate-right.
- Single clock domain; used as a general-purpose data-path element.
- Register contents drive the output port directly.

Parameters:
- WIDTH, 4, register and data width in bits; legal range is 2 or more.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-low reset. The port name is rst but the signal is active-low: 0 resets, 1 runs.
- ip  input  WIDTH  parallel load data.
- load  input  1  parallel-load request; priority over sel.
- sel  input  2  operation select when load=0.
- op  output  WIDTH  current register contents; registered output, no combinational path from inputs.

Behaviour:
- Reset
  - rst=0 clears op to all zeros immediately, independent of clk.
  - Reset asserted mid-operation aborts the operation; contents are lost.
  - First rising edge after rst returns to 1 performs a normal update using that edge's inputs.
- All updates happen on the rising clk edge while rst=1. Latency is one cycle: the op change is visible after the edge that sampled the inputs.
- Update priority, evaluated per edge:
  - load=1: op <= ip, regardless of sel.
  - load=0, sel=00: hold; op unchanged.
  - load=0, sel=01: logical shift right. op <= {1'b0, op[WIDTH-1:1]}; the MSB fills with 0 and the LSB is discarded.
  - load=0, sel=10: logical shift left. op <= {op[WIDTH-2:0], 1'b0}; the LSB fills with 0.
  - load=0, sel=11: rotate right. op <= {op[0], op[WIDTH-1:1]}.
- Boundary behaviour
  - Repeated shifts of the same direction reach all zeros after WIDTH cycles and stay there.
  - Rotate wraps indefinitely; the original value returns after WIDTH cycles.
  - load and sel changing together: load wins, and sel is ignored that cycle.
- X/Z handling
  - X/Z on sel with load=0 is not a legal operating condition.
  - The implementation must hold op in that case: a default branch assigns op to itself, with no latch.
- ip is don't-care unless load=1.

Optional Feature:
- Macro: SHIFT_REG_ARITH_EN.
- Defined:
  - sel=01 becomes arithmetic shift right: op <= {op[WIDTH-1], op[WIDTH-1:1]}, so the MSB is replicated.
  - All other modes are unchanged.
- Undefined:
  - sel=01 is a logical shift right with zero fill, as in Behaviour.

Decomposition:
- Package shift_reg_pkg:
  - A 2-bit enum for the sel codes: MODE_HOLD=2'b00, MODE_SHR=2'b01, MODE_SHL=2'b10, MODE_ROR=2'b11.
  - A default WIDTH constant.
- Sub-module shift_reg_next (optional):
  - Purely combinational next-state function with inputs cur, ip, load and sel, and output nxt.
  - Keeps the sequential wrapper trivial and allows next-state unit checks without a clock.
- A single-module implementation is also acceptable.

Test Plan (all scenarios use WIDTH=4):
- Reset: rst=0, load=1, ip=1100 -> op=0000 immediately, and it stays 0000 across clock edges while rst=0. Then rst=1 -> op=1100 after the next edge.
- Load and hold:
  - load=1, ip=1100 -> op=1100.
  - load=0, sel=00, ip changed to 0101 -> op stays 1100 for 3 edges.
- Shift right:
  - load=1, ip=1000 -> op=1000.
  - load=0, sel=01 -> 0100, 0010, 0001, 0000, 0000.
  - With SHIFT_REG_ARITH_EN, the same stimulus gives 1100, 1110, 1111.
- Shift left:
  - load=1, ip=1010 -> op=1010.
  - load=0, sel=10 -> 0100, 1000, 0000.
- Rotate:
  - load=1, ip=1110 -> op=1110.
  - load=0, sel=11 -> 0111, 1011, 1101, 1110, returning to the original value after 4 edges.
- Priority and async reset:
  - load=1, sel=11, ip=1111 -> op=1111, with no rotate.
  - Then rst pulsed low between edges -> op=0000 before the next edge.
